// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch with one outstanding imem read, a registered
//               decode handshake and branch redirect/flush. Optional
//               misaligned-target trap via `FETCH_MISALIGN_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================

package pkg_config;
    localparam int DATA_WIDTH = 32;
endpackage

module fetch_unit
    import pkg_config::*;
#(
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  take_i,
    input  logic [DATA_WIDTH-1:0] target_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  misaligned_o
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] C_PC_STEP = 32'd4;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;
    logic                  valid_q, valid_d;
    logic                  misaligned_q, misaligned_d;

    logic                  w_transfer;
    logic                  w_issue;
    logic                  w_target_bad;
    logic [DATA_WIDTH-1:0] w_redirect_pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign w_target_bad  = |target_i[1:0];
    assign w_redirect_pc = target_i;
`else
    logic w_target_low_unused;
    assign w_target_low_unused = ^target_i[1:0];
    assign w_target_bad        = 1'b0;
    assign w_redirect_pc       = {target_i[DATA_WIDTH-1:2], 2'b00};
`endif

    assign w_transfer = valid_q & instr_ready_i;
    // Issue only when the response is guaranteed a free output slot on arrival.
    assign w_issue    = !rst_i && (state_q == S_FETCH) && !take_i
                        && (!valid_q || instr_ready_i);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        misaligned_d = 1'b0;

        if (w_transfer) begin
            valid_d = 1'b0;
        end

        if (take_i) begin
            valid_d = 1'b0;
            if (w_target_bad) begin
                misaligned_d = 1'b1;
            end else begin
                pc_d = w_redirect_pc;
            end
            // A request still in flight must be swallowed before fetching again.
            if ((state_q == S_FETCH) || imem_rvalid_i) begin
                state_d = S_FETCH;
            end else begin
                state_d = S_DISCARD;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (w_issue) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        instr_d  = imem_rdata_i;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + C_PC_STEP;
                        state_d  = S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (imem_rvalid_i) begin
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign imem_req_o    = w_issue;
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_out_q;
    assign misaligned_o  = misaligned_q;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL size all address/data ports to DATA_WIDTH from pkg_config (32).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 SHALL have port take_i, input, 1, branch-taken decision from branch_unit take_o.
REQ-006 SHALL have port target_i, input, 32, redirect address, valid when take_i=1.
REQ-007 SHALL have port imem_req_o, output, 1, instruction-memory read request, one cycle per request.
REQ-008 SHALL have port imem_addr_o, output, 32, request address, valid with imem_req_o.
REQ-009 SHALL have port imem_rvalid_i, input, 1, read-data valid; in order, at most one outstanding, latency >=1 cycle.
REQ-010 SHALL have port imem_rdata_i, input, 32, instruction word, valid with imem_rvalid_i.
REQ-011 SHALL have port instr_valid_o, output, 1, instr_o/pc_o hold a valid fetched instruction.
REQ-012 SHALL have port instr_ready_i, input, 1, decode accepts; transfer when instr_valid_o and instr_ready_i are both 1.
REQ-013 SHALL have port instr_o, output, 32, fetched instruction word.
REQ-014 SHALL have port pc_o, output, 32, address of instr_o.
REQ-015 SHALL have port misaligned_o, output, 1, one-cycle misaligned-target pulse (see Configuration).

Function
REQ-016 SHALL implement states FETCH (may issue), WAIT (valid request outstanding), DISCARD (stale request outstanding).
REQ-017 SHALL assert imem_req_o in FETCH only if output register is empty or transfers this cycle, and take_i=0; imem_addr_o=PC; next state WAIT.
REQ-018 SHALL, in WAIT on imem_rvalid_i, load instr_o=imem_rdata_i, pc_o=request address, set instr_valid_o next cycle, set PC=PC+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), return to FETCH.
REQ-019 SHALL hold instr_o, pc_o, instr_valid_o stable while instr_valid_o=1 and instr_ready_i=0.
REQ-020 SHALL clear instr_valid_o on a transfer unless a new response loads the same cycle.
REQ-021 SHALL give take_i priority over all events: at the edge, PC=target_i, instr_valid_o=0 next cycle, no request issued that cycle.
REQ-022 SHALL, on take_i in WAIT or DISCARD without imem_rvalid_i, enter DISCARD; on take_i coincident with imem_rvalid_i, drop the response and enter FETCH.
REQ-023 SHALL, in DISCARD, drop the arriving response (no output load, no PC increment) and enter FETCH.
REQ-024 SHALL use the latest target_i when take_i repeats in consecutive cycles.
REQ-025 SHALL achieve fetch latency request-to-instr_valid_o of memory latency + 1 cycle; throughput one instruction per 2 cycles at latency 1.

Reset
REQ-026 SHALL, while rst_i=1, set state FETCH, PC=RESET_PC, imem_req_o=0, instr_valid_o=0, instr_o=0, pc_o=0, misaligned_o=0.
REQ-027 SHALL issue the first request (imem_addr_o=RESET_PC) in the first cycle after rst_i falls.
REQ-028 SHALL, on reset mid-WAIT, ignore any imem_rvalid_i for the abandoned request arriving in the first cycle after reset (memory is reset concurrently by system contract).

Configuration
REQ-029 SHALL, with FETCH_MISALIGN_CHECK_EN defined, on take_i with target_i[1:0]!=0: pulse misaligned_o one cycle after, leave PC unchanged, still flush per REQ-021/022.
REQ-030 SHALL, without FETCH_MISALIGN_CHECK_EN, force target_i[1:0] to 2'b00 on redirect and tie misaligned_o to 0.

Verification
REQ-031 SHALL cover reset release, latency 1, ready=1 -> addresses 0x0,0x4,0x8; instr_valid_o with pc_o 0x0 two cycles after first request.
REQ-032 SHALL cover instr_ready_i=0 for 5 cycles with instr_o=0x00500093 -> outputs stable, no new imem_req_o.
REQ-033 SHALL cover take_i=1, target_i=0x100 during WAIT (latency 3) -> stale response dropped, next imem_addr_o=0x100, no instr_valid_o for stale PC.
REQ-034 SHALL cover take_i coincident with imem_rvalid_i, target_i=0x40 -> response dropped, next request 0x40.
REQ-035 SHALL cover target_i=0x102: with macro misaligned_o=1 one cycle and PC unchanged; without macro next request 0x100.
REQ-036 SHALL cover RESET_PC=0xFFFF_FFFC -> second request address 0x0000_0000.
